// File: rtl/axis_idle_tlast.sv
// Idle-gap packet delimiter for a byte stream: holds one beat back and tags it
// with tlast on an idle timeout, an input tlast, or a maximum packet length.
module axis_idle_tlast #(
  parameter int unsigned AXIS_BYTES      = 1,
  parameter int unsigned TIMEOUT_CYCLES  = 1000,
  parameter int unsigned MAX_PACKET      = 0,
  parameter int unsigned USE_INPUT_TLAST = 0
) (
  input  logic                    clk,
  input  logic                    sreset,
  output logic                    axis_i_tready,
  input  logic                    axis_i_tvalid,
  input  logic                    axis_i_tlast,
  input  logic [AXIS_BYTES*8-1:0] axis_i_tdata,
  input  logic                    axis_o_tready,
  output logic                    axis_o_tvalid,
  output logic                    axis_o_tlast,
  output logic [AXIS_BYTES*8-1:0] axis_o_tdata
);

  localparam int unsigned DW        = AXIS_BYTES * 8;
  localparam int unsigned TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BW        = (MAX_PACKET > 1) ? $clog2(MAX_PACKET) : 1;
  localparam int unsigned BEAT_LAST = (MAX_PACKET == 0) ? 0 : MAX_PACKET - 1;

  logic          hv_q, hv_d;
  logic [DW-1:0] hd_q, hd_d;
  logic          hl_q, hl_d;
  logic          ov_q, ov_d;
  logic [DW-1:0] od_q, od_d;
  logic          ol_q, ol_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [BW-1:0] beat_q, beat_d;

  logic out_free;
  logic in_ready;
  logic accept;
  logic timeout;
  logic pkt_full;
  logic move;
  logic move_last;

  // Handshake qualifiers and the hold-to-output transfer decision
  always_comb begin
    out_free  = !ov_q || axis_o_tready;
    in_ready  = !sreset && (!hv_q || out_free);
    accept    = axis_i_tvalid && in_ready;
    timeout   = hv_q && (timer_q == TW'(TIMEOUT_CYCLES));
    pkt_full  = (MAX_PACKET != 0) && (beat_q == BW'(BEAT_LAST));
    move      = hv_q && out_free && (accept || timeout || hl_q);
    move_last = timeout || hl_q || pkt_full;
  end

  // Next-state for hold register, output register, idle timer and beat counter
  always_comb begin
    hv_d    = hv_q;
    hd_d    = hd_q;
    hl_d    = hl_q;
    ov_d    = ov_q;
    od_d    = od_q;
    ol_d    = ol_q;
    timer_d = timer_q;
    beat_d  = beat_q;

    if (accept) begin
      hv_d    = 1'b1;
      hd_d    = axis_i_tdata;
      hl_d    = (USE_INPUT_TLAST != 0) ? axis_i_tlast : 1'b0;
      timer_d = '0;
    end else begin
      if (move) begin
        hv_d = 1'b0;
      end
      // Saturating: a held beat stuck behind backpressure keeps its timeout
      if (hv_q && (timer_q != TW'(TIMEOUT_CYCLES))) begin
        timer_d = timer_q + TW'(1);
      end
    end

    if (move) begin
      ov_d   = 1'b1;
      od_d   = hd_q;
      ol_d   = move_last;
      beat_d = move_last ? '0 : beat_q + BW'(1);
    end else if (axis_o_tready) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      hv_q    <= 1'b0;
      hd_q    <= '0;
      hl_q    <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      ol_q    <= 1'b0;
      timer_q <= '0;
      beat_q  <= '0;
    end else begin
      hv_q    <= hv_d;
      hd_q    <= hd_d;
      hl_q    <= hl_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      ol_q    <= ol_d;
      timer_q <= timer_d;
      beat_q  <= beat_d;
    end
  end

  assign axis_i_tready = in_ready;
  assign axis_o_tvalid = ov_q;
  assign axis_o_tlast  = ol_q;
  assign axis_o_tdata  = od_q;

endmodule

// File: tb/tb_axis_idle_tlast.sv
// Bench for axis_idle_tlast: directed vector table, hand-written corner cases,
// and random traffic checked by a beat-level scoreboard.
module tb_axis_idle_tlast;

  localparam int unsigned TO = 1000;
  localparam int unsigned MP = 4;

  logic       clk           = 1'b0;
  logic       sreset        = 1'b1;
  logic       axis_i_tready;
  logic       axis_i_tvalid = 1'b0;
  logic       axis_i_tlast  = 1'b0;
  logic [7:0] axis_i_tdata  = 8'h00;
  logic       axis_o_tready = 1'b1;
  logic       axis_o_tvalid;
  logic       axis_o_tlast;
  logic [7:0] axis_o_tdata;

  axis_idle_tlast #(
    .AXIS_BYTES     (1),
    .TIMEOUT_CYCLES (TO),
    .MAX_PACKET     (MP),
    .USE_INPUT_TLAST(1)
  ) u_dut (
    .clk          (clk),
    .sreset       (sreset),
    .axis_i_tready(axis_i_tready),
    .axis_i_tvalid(axis_i_tvalid),
    .axis_i_tlast (axis_i_tlast),
    .axis_i_tdata (axis_i_tdata),
    .axis_o_tready(axis_o_tready),
    .axis_o_tvalid(axis_o_tvalid),
    .axis_o_tlast (axis_o_tlast),
    .axis_o_tdata (axis_o_tdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct {
    int         gap;
    logic [7:0] data;
    logic       in_last;
    logic       exp_last;
  } vec_t;

  int      errors = 0;
  int      checks = 0;
  longint  cyc    = 0;

  beat_t   exp_q[$];
  beat_t   act_q[$];
  beat_t   log_q[$];
  bit      pend_v    = 1'b0;
  beat_t   pend;
  longint  pend_t    = 0;
  int      model_cnt = 0;
  int      inflight  = 0;
  bit      prev_stall = 1'b0;
  beat_t   prev_out;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // A beat's tlast is fixed once the gap to the next accepted beat is known
  function automatic void finalize(input longint gap);
    beat_t b;
    b.data    = pend.data;
    b.last    = pend.last || (gap > longint'(TO)) || (model_cnt == int'(MP) - 1);
    model_cnt = b.last ? 0 : model_cnt + 1;
    exp_q.push_back(b);
    pend_v    = 1'b0;
  endfunction

  task automatic compare_queues();
    beat_t a;
    beat_t e;
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      chk(a === e, "stream", 64'(a), 64'(e));
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor and scoreboard, sampled mid-cycle
  initial forever begin
    beat_t cur;
    bit    exp_rdy;
    @(negedge clk);
    cur.data = axis_o_tdata;
    cur.last = axis_o_tlast;
    if (prev_stall)
      chk(axis_o_tvalid === 1'b1 && cur === prev_out, "hold_stable",
          {55'd0, axis_o_tvalid, cur}, {55'd0, 1'b1, prev_out});
    exp_rdy = !sreset && !(inflight == 2 && !axis_o_tready);
    chk(axis_i_tready === exp_rdy, "in_tready", 64'(axis_i_tready), 64'(exp_rdy));
    prev_stall = (axis_o_tvalid === 1'b1) && !axis_o_tready && !sreset;
    prev_out   = cur;
    if (sreset) begin
      compare_queues();
      exp_q.delete();
      act_q.delete();
      pend_v    = 1'b0;
      inflight  = 0;
      model_cnt = 0;
    end else begin
      if (axis_i_tvalid && axis_i_tready === 1'b1) begin
        if (pend_v) finalize(cyc + 1 - pend_t);
        pend.data = axis_i_tdata;
        pend.last = axis_i_tlast;
        pend_t    = cyc + 1;
        pend_v    = 1'b1;
        inflight++;
      end
      if (axis_o_tvalid === 1'b1 && axis_o_tready) begin
        act_q.push_back(cur);
        log_q.push_back(cur);
        inflight--;
      end
      compare_queues();
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l, input bit rnd);
    bit ok = 1'b0;
    axis_i_tvalid = 1'b1;
    axis_i_tdata  = d;
    axis_i_tlast  = l;
    for (int k = 0; k < 4000 && !ok; k++) begin
      if (rnd) axis_o_tready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      ok = (axis_i_tready === 1'b1);
      @(posedge clk);
      #1;
    end
    axis_i_tvalid = 1'b0;
    axis_i_tlast  = 1'b0;
    if (!ok) chk(1'b0, "accept_timeout", 64'd0, 64'd1);
  endtask

  // Called right after an isolated accept with the output free
  task automatic check_release(input logic [7:0] d, input string tag);
    int k = 0;
    @(negedge clk);
    while (axis_o_tvalid !== 1'b1 && k < 3 * int'(TO)) begin
      @(negedge clk);
      k++;
    end
    chk(k == int'(TO) + 1, {tag, "_latency"}, 64'(k), 64'(TO + 1));
    chk(axis_o_tdata === d && axis_o_tlast === 1'b1, {tag, "_beat"},
        {55'd0, axis_o_tdata, axis_o_tlast}, {55'd0, d, 1'b1});
    @(negedge clk);
    chk(axis_o_tvalid === 1'b0, {tag, "_single"}, 64'(axis_o_tvalid), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_log(input beat_t exp[], input string tag);
    chk(log_q.size() == exp.size(), {tag, "_count"}, 64'(log_q.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < log_q.size(); i++)
      chk(log_q[i] === exp[i], {tag, "_beat"}, 64'(log_q[i]), 64'(exp[i]));
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1);
  end

  initial begin
    vec_t  tbl[15];
    beat_t exp_b[];

    // gap = idle cycles before the beat; exp_last assumes the next row's gap
    tbl[0]  = '{0,    8'h01, 1'b0, 1'b0};
    tbl[1]  = '{249,  8'h02, 1'b0, 1'b0};
    tbl[2]  = '{249,  8'h03, 1'b0, 1'b1};
    tbl[3]  = '{1100, 8'h10, 1'b0, 1'b0};
    tbl[4]  = '{0,    8'h11, 1'b0, 1'b0};
    tbl[5]  = '{0,    8'h12, 1'b0, 1'b0};
    tbl[6]  = '{0,    8'h13, 1'b0, 1'b1};
    tbl[7]  = '{0,    8'h14, 1'b0, 1'b0};
    tbl[8]  = '{0,    8'h15, 1'b0, 1'b1};
    tbl[9]  = '{1100, 8'h20, 1'b1, 1'b1};
    tbl[10] = '{0,    8'h21, 1'b0, 1'b0};
    tbl[11] = '{0,    8'h22, 1'b0, 1'b1};
    tbl[12] = '{1100, 8'h30, 1'b0, 1'b0};
    tbl[13] = '{999,  8'h31, 1'b0, 1'b1};
    tbl[14] = '{1000, 8'h32, 1'b0, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk(axis_o_tvalid === 1'b0, "rst_tvalid", 64'(axis_o_tvalid), 64'd0);
    chk(axis_o_tlast === 1'b0, "rst_tlast", 64'(axis_o_tlast), 64'd0);
    chk(axis_o_tdata === 8'h00, "rst_tdata", 64'(axis_o_tdata), 64'd0);
    chk(axis_i_tready === 1'b0, "rst_tready", 64'(axis_i_tready), 64'd0);
    @(posedge clk);
    #1;
    sreset = 1'b0;
    idle(6);

    // Isolated beat released by the idle timeout
    send_beat(8'hA5, 1'b0, 1'b0);
    check_release(8'hA5, "single");
    idle(10);

    // Vector table: spacing, max-packet, input tlast and timeout boundary
    log_q.delete();
    for (int i = 0; i < 15; i++) begin
      idle(tbl[i].gap);
      send_beat(tbl[i].data, tbl[i].in_last, 1'b0);
    end
    idle(int'(TO) + 20);
    exp_b = new[15];
    for (int i = 0; i < 15; i++) begin
      exp_b[i].data = tbl[i].data;
      exp_b[i].last = tbl[i].exp_last;
    end
    check_log(exp_b, "table");

    // Backpressure: two beats fill the block, the third must wait
    log_q.delete();
    axis_o_tready = 1'b0;
    axis_i_tvalid = 1'b1;
    axis_i_tdata  = 8'h41;
    @(negedge clk);
    chk(axis_i_tready === 1'b1, "bp_rdy1", 64'(axis_i_tready), 64'd1);
    @(posedge clk);
    #1;
    axis_i_tdata = 8'h42;
    @(negedge clk);
    chk(axis_i_tready === 1'b1, "bp_rdy2", 64'(axis_i_tready), 64'd1);
    @(posedge clk);
    #1;
    axis_i_tdata = 8'h43;
    @(negedge clk);
    chk(axis_i_tready === 1'b0, "bp_full", 64'(axis_i_tready), 64'd0);
    chk(axis_o_tvalid === 1'b1 && axis_o_tdata === 8'h41, "bp_head",
        {55'd0, axis_o_tvalid, axis_o_tdata}, {55'd0, 1'b1, 8'h41});
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk(axis_i_tready === 1'b0, "bp_still_full", 64'(axis_i_tready), 64'd0);
    @(posedge clk);
    #1;
    axis_o_tready = 1'b1;
    @(negedge clk);
    chk(axis_i_tready === 1'b1, "bp_release", 64'(axis_i_tready), 64'd1);
    @(posedge clk);
    #1;
    axis_i_tvalid = 1'b0;
    idle(int'(TO) + 20);
    exp_b = new[3];
    exp_b[0] = '{8'h41, 1'b0};
    exp_b[1] = '{8'h42, 1'b0};
    exp_b[2] = '{8'h43, 1'b1};
    check_log(exp_b, "bp");

    // Reset with both registers occupied discards them
    axis_o_tready = 1'b0;
    send_beat(8'h51, 1'b0, 1'b0);
    send_beat(8'h52, 1'b0, 1'b0);
    log_q.delete();
    sreset = 1'b1;
    @(negedge clk);
    chk(axis_i_tready === 1'b0, "rst2_tready", 64'(axis_i_tready), 64'd0);
    @(posedge clk);
    #1;
    sreset = 1'b0;
    @(negedge clk);
    chk(axis_o_tvalid === 1'b0, "rst2_tvalid", 64'(axis_o_tvalid), 64'd0);
    @(posedge clk);
    #1;
    axis_o_tready = 1'b1;
    idle(20);
    chk(log_q.size() == 0, "rst2_no_stale", 64'(log_q.size()), 64'd0);
    send_beat(8'h77, 1'b0, 1'b0);
    check_release(8'h77, "rst2_fresh");
    idle(10);

    // Random traffic with random backpressure against the scoreboard
    for (int i = 0; i < 300; i++) begin
      int r;
      int gap;
      r   = int'($urandom_range(0, 99));
      gap = (r < 5) ? int'($urandom_range(TO - 2, TO + 2)) : ((r < 40) ? int'($urandom_range(1, 6)) : 0);
      repeat (gap) begin
        axis_o_tready = ($urandom_range(0, 9) < 7);
        @(posedge clk);
        #1;
      end
      send_beat(8'($urandom), ($urandom_range(0, 7) == 0), 1'b1);
    end
    axis_o_tready = 1'b1;
    idle(int'(TO) + 20);
    if (pend_v) finalize(64'h7fff_ffff_ffff);
    compare_queues();
    chk(exp_q.size() == 0 && act_q.size() == 0, "sb_drain",
        64'(act_q.size()), 64'(exp_q.size()));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
